serial_subtractor: RTL and testbench

Bit-serial, parametrised-width subtractor built on a full-subtractor cell and a registered borrow. It computes diff = a - b - bin over WIDTH clock cycles, processing one bit per cycle LSB-first, and uses a start/busy/done handshake. It is the area-lean, multi-bit successor to the combinational single-bit full subtractor. It is intended for datapaths where throughput is not critical.

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_subtractor.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one bit per clock LSB-first, through a full-subtractor
// cell with a registered borrow. Results stay held until the next completion.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one operand bit per cycle, count = bit index
// DONE  | one-cycle result pulse, may accept the next start
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_subtractor_if.slave sub_if
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;

    logic             d_bit;
    logic             br_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] res_sh;

    assign d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nxt   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // New difference bit enters at the MSB so bit 0 ends at the LSB after WIDTH shifts.
    always_comb begin
        res_sh            = res_q >> 1;
        res_sh[WIDTH-1]   = d_bit;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;

        case (state_q)
            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_sh;
                br_d  = br_nxt;
                if (last_bit) begin
                    diff_d  = res_sh;
                    bout_d  = br_nxt;
                    // d_bit is the result MSB on the final cycle
                    ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (sub_if.start) begin
                    a_d     = sub_if.a;
                    b_d     = sub_if.b;
                    br_d    = sub_if.bin;
                    a_msb_d = sub_if.a[WIDTH-1];
                    b_msb_d = sub_if.b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign sub_if.busy = (state_q == S_SHIFT);
    assign sub_if.done = (state_q == S_DONE);
    assign sub_if.diff = diff_q;
    assign sub_if.bout = bout_q;
    assign sub_if.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 8, 4 and 1 against an arithmetic model.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();
    serial_subtractor_if #(.WIDTH(1)) if1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .sub_if(if8.slave));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .sub_if(if4.slave));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .sub_if(if1.slave));

    // expected visible result of the 8-bit DUT: {bout, ovf, diff}
    logic [9:0] last8;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input int w, input int a, input int b, input int bin,
                                  output int d, output bit bo, output bit ov);
        int half, r, sa, sb, sr;
        half = 1 << (w - 1);
        r    = a - b - bin;
        bo   = (r < 0);
        d    = r & ((1 << w) - 1);
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        sr   = sa - sb - bin;
        ov   = (sr < -half) || (sr > half - 1);
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [9:0] res, output int lat, output int busy_cnt,
                       output logic held_ok);
        if8.a = a; if8.b = b; if8.bin = bin; if8.start = 1'b1;
        lat = 0; busy_cnt = 0; held_ok = 1'b1;
        tick();
        if8.start = 1'b0;
        lat = 1;
        while (!if8.done && lat < 60) begin
            if (if8.busy) busy_cnt++;
            if ({if8.bout, if8.ovf, if8.diff} !== last8) held_ok = 1'b0;
            if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
            tick();
            lat++;
        end
        res = {if8.bout, if8.ovf, if8.diff};
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                       output logic [5:0] res, output int lat);
        if4.a = a; if4.b = b; if4.bin = bin; if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        lat = 1;
        while (!if4.done && lat < 60) begin
            tick();
            lat++;
        end
        res = {if4.bout, if4.ovf, if4.diff};
    endtask

    task automatic op1(input logic a, input logic b, input logic bin,
                       output logic [2:0] res, output int lat);
        if1.a = a; if1.b = b; if1.bin = bin; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        lat = 1;
        while (!if1.done && lat < 60) begin
            tick();
            lat++;
        end
        res = {if1.bout, if1.ovf, if1.diff};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;
        last8 = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({if8.busy, if8.done, if8.bout, if8.ovf, if8.diff} !== 12'h000) begin
            failures++;
            $display("FAIL reset8 got=%h want=000", {if8.busy, if8.done, if8.bout, if8.ovf, if8.diff});
        end
        checks++;
        if ({if4.busy, if4.done, if4.bout, if4.ovf, if4.diff} !== 8'h00) begin
            failures++;
            $display("FAIL reset4 got=%h want=00", {if4.busy, if4.done, if4.bout, if4.ovf, if4.diff});
        end
        checks++;
        if ({if1.busy, if1.done, if1.bout, if1.ovf, if1.diff} !== 5'h00) begin
            failures++;
            $display("FAIL reset1 got=%h want=00", {if1.busy, if1.done, if1.bout, if1.ovf, if1.diff});
        end
    endtask

    task automatic test_width1;
        logic [1:0] tbl [8];
        logic [2:0] res, idx;
        int lat, d;
        bit bo, ov;
        tbl = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            op1(idx[2], idx[1], idx[0], res, lat);
            model(1, int'(idx[2]), int'(idx[1]), int'(idx[0]), d, bo, ov);
            checks++;
            if ({res[0], res[2]} !== tbl[i] || lat != 2) begin
                failures++;
                $display("FAIL w1_truth abc=%b got=%b lat=%0d want=%b lat=2", idx, {res[0], res[2]}, lat, tbl[i]);
            end
            checks++;
            if (res[1] !== ov) begin
                failures++;
                $display("FAIL w1_ovf abc=%b got=%b want=%b", idx, res[1], ov);
            end
            tick();
        end
    endtask

    task automatic test_width4;
        logic [5:0] res, exp;
        int lat, d;
        bit bo, ov;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    op4(4'(a), 4'(b), 1'(c), res, lat);
                    model(4, a, b, c, d, bo, ov);
                    exp = {bo, ov, d[3:0]};
                    checks++;
                    if (res !== exp || lat != 5) begin
                        failures++;
                        $display("FAIL w4_sweep a=%0d b=%0d bin=%0d got=%h lat=%0d want=%h lat=5",
                                 a, b, c, res, lat, exp);
                    end
                end
        tick();
    endtask

    task automatic test_directed8;
        logic [7:0]  va [4];
        logic [7:0]  vb [4];
        logic        vc [4];
        logic [9:0]  ve [4];
        logic [9:0]  res;
        int lat, bc;
        logic held;
        va = '{8'h05, 8'h03, 8'h00, 8'h80};
        vb = '{8'h03, 8'h05, 8'h00, 8'h01};
        vc = '{1'b0, 1'b0, 1'b1, 1'b0};
        ve = '{{2'b00, 8'h02}, {2'b10, 8'hFE}, {2'b10, 8'hFF}, {2'b01, 8'h7F}};
        for (int i = 0; i < 4; i++) begin
            op8(va[i], vb[i], vc[i], res, lat, bc, held);
            checks++;
            if (res !== ve[i]) begin
                failures++;
                $display("FAIL dir8_result idx=%0d got=%h want=%h", i, res, ve[i]);
            end
            checks++;
            if (lat != 9 || bc != 8) begin
                failures++;
                $display("FAIL dir8_timing idx=%0d lat=%0d busy=%0d want lat=9 busy=8", i, lat, bc);
            end
            checks++;
            if (held !== 1'b1) begin
                failures++;
                $display("FAIL dir8_held idx=%0d got=%b want=1 prior=%h", i, held, last8);
            end
            last8 = ve[i];
            tick();
        end
    endtask

    task automatic test_random8;
        logic [7:0] a, b;
        logic       c;
        logic [9:0] res, exp;
        int lat, bc, d;
        bit bo, ov;
        logic held;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            op8(a, b, c, res, lat, bc, held);
            model(8, int'(a), int'(b), int'(c), d, bo, ov);
            exp = {bo, ov, d[7:0]};
            checks++;
            if (res !== exp || lat != 9 || held !== 1'b1) begin
                failures++;
                $display("FAIL rand8 a=%h b=%h bin=%b got=%h lat=%0d held=%b want=%h lat=9 held=1",
                         a, b, c, res, lat, held, exp);
            end
            last8 = exp;
            if ($urandom_range(1, 0) == 1) tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] qa [5];
        logic [7:0] qb [5];
        logic       qc [5];
        logic [9:0] exp;
        int k, gap, edges, d;
        bit bo, ov;
        for (int i = 0; i < 4; i++) begin
            qa[i] = 8'($urandom); qb[i] = 8'($urandom); qc[i] = 1'($urandom);
        end
        qa[4] = 8'h80; qb[4] = 8'h01; qc[4] = 1'b0;
        k = 0; gap = 0; edges = 0;
        if8.a = qa[0]; if8.b = qb[0]; if8.bin = qc[0]; if8.start = 1'b1;
        while (k < 5 && edges < 200) begin
            tick();
            edges++;
            gap++;
            if (if8.done) begin
                model(8, int'(qa[k]), int'(qb[k]), int'(qc[k]), d, bo, ov);
                exp = {bo, ov, d[7:0]};
                checks++;
                if ({if8.bout, if8.ovf, if8.diff} !== exp || gap != 9) begin
                    failures++;
                    $display("FAIL b2b op=%0d got=%h gap=%0d want=%h gap=9",
                             k, {if8.bout, if8.ovf, if8.diff}, gap, exp);
                end
                last8 = exp;
                gap = 0;
                k++;
                if (k < 5) begin
                    if8.a = qa[k]; if8.b = qb[k]; if8.bin = qc[k];
                end else begin
                    if8.start = 1'b0;
                end
            end else begin
                if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
            end
        end
        if8.start = 1'b0;
        checks++;
        if (k != 5) begin
            failures++;
            $display("FAIL b2b_timeout completed=%0d want=5", k);
        end
        tick();
    endtask

    task automatic test_mid_reset;
        logic seen;
        if8.a = 8'h12; if8.b = 8'h34; if8.bin = 1'b1; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        repeat (3) tick();
        checks++;
        if (if8.busy !== 1'b1 || {if8.bout, if8.ovf, if8.diff} !== last8) begin
            failures++;
            $display("FAIL midrst_pre busy=%b res=%h want busy=1 res=%h", if8.busy,
                     {if8.bout, if8.ovf, if8.diff}, last8);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({if8.busy, if8.done, if8.bout, if8.ovf, if8.diff} !== 12'h000) begin
            failures++;
            $display("FAIL midrst_async got=%h want=000", {if8.busy, if8.done, if8.bout, if8.ovf, if8.diff});
        end
        last8 = '0;
        tick();
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (if8.done || if8.busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || {if8.bout, if8.ovf, if8.diff} !== last8) begin
            failures++;
            $display("FAIL midrst_nodone activity=%b res=%h want activity=0 res=000", seen,
                     {if8.bout, if8.ovf, if8.diff});
        end
    endtask

    initial begin
        test_reset();
        test_width1();
        test_width4();
        test_directed8();
        test_random8();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
